commit_queue: RTL and testbench
===============================

// Module: commit_queue
// PURPOSE
//  In-order commit buffer that feeds the commit stage. Issue allocates entries in program order.
//  Writeback ports mark entries done, with a result or an exception. The oldest NR_COMMIT_PORTS
//  entries are presented as commit_instr_o; entries retire when the commit stage returns commit_ack_i.
//  Sits between issue/writeback and commit_stage; it is the producer end of the commit_instr/commit_ack interface.
// PARAMETERS
//  CVA6Cfg          config_pkg::cva6_cfg_empty  core config; NrCommitPorts and NrWbPorts are taken from here
//  NR_ENTRIES       8                           queue depth; power of two, >= 2*NrCommitPorts
// PORTS
//  clk_i            in   1                        clock, all state on rising edge
//  rst_i            in   1                        synchronous, active-high reset
//  flush_i          in   1                        discard all entries (misprediction/exception)
//  issue_valid_i    in   1                        issue wants to allocate one entry
//  issue_instr_i    in   scoreboard_entry_t       decoded instruction; valid field ignored
//  issue_ready_o    out  1                        free slot available
//  issue_trans_id_o out  TRANS_ID_BITS            slot index of allocated entry (= tail pointer)
//  wb_valid_i       in   NrWbPorts                writeback strobe per port
//  wb_trans_id_i    in   NrWbPorts x TRANS_ID_BITS target slot
//  wb_result_i      in   NrWbPorts x XLEN         result data
//  wb_ex_i          in   NrWbPorts x exception_t  exception from FU
//  commit_instr_o   out  NrCommitPorts x scoreboard_entry_t  head entries; [0] is oldest
//  commit_ack_i     in   NrCommitPorts            retire strobe from commit stage
//  empty_o          out  1                        no occupied entries
// BEHAVIOUR
//  Reset (rst_i=1 at clock edge): head=tail=count=0, all slot occupied/done bits clear.
//    Resulting outputs: issue_ready_o=1, empty_o=1, commit_instr_o[*].valid=0.
//  Alloc: fires on issue_valid_i & issue_ready_o. issue_ready_o = (count != NR_ENTRIES),
//    computed from the registered count only; a same-cycle pop does not free a slot for that cycle's alloc.
//    Alloc writes issue_instr_i to slot[tail], sets occupied=1 and done=0, and increments tail mod NR_ENTRIES.
//  Writeback: for each port k with wb_valid_i[k] and slot[wb_trans_id_i[k]] occupied:
//    write result and ex, set done=1. A writeback to an unoccupied slot is ignored.
//    Two ports targeting the same slot in one cycle is illegal (assertion); the higher port index wins.
//  Present: commit_instr_o[i] = slot[(head+i) mod NR_ENTRIES], for i < count.
//    .valid = occupied & done; .trans_id = slot index; entries at i >= count have valid=0.
//  Retire: commit_ack_i must be prefix-contiguous (ack[i] implies ack[i-1]); a gap is an assertion error.
//    An ack on an entry with valid=0 is also an assertion error.
//    npop = number of acks; head += npop mod NR_ENTRIES; the retired slots are cleared.
//  count_next = count + alloc - npop. Pointers wrap naturally.
//    count reaching NR_ENTRIES means full; head==tail is disambiguated by count.
//  Flush: flush_i at a clock edge forces the reset state. It overrides same-cycle alloc, writeback and ack.
//    issue_trans_id_o restarts at 0 after a flush.
//  Reset or flush mid-stream: the commit side sees all valid=0 starting the next cycle; no partial retire.
//  Latency: alloc->presentable takes 1 cycle; writeback->commit_instr_o.valid takes 1 cycle
//    (0 cycles with bypass, see CONFIGURATION).
// CONFIGURATION
//  COMMIT_QUEUE_WB_BYPASS_EN defined: commit_instr_o combinationally reflects same-cycle writebacks to
//    the presented head slots (valid, result and ex are forwarded), giving writeback->commit latency 0.
//    The registered update is unchanged.
//  Not defined: commit_instr_o is driven purely from registers.
// STRUCTURE
//  ariane_pkg: TRANS_ID_BITS = $clog2(NR_ENTRIES); cq_ptr_t; cq_slot_t {occupied, done, scoreboard_entry_t}.
//  Sub-module commit_queue_ptr: wrapping pointer register with increment 0..NrCommitPorts, sync clear.
//    Instantiated twice, once for head and once for tail.
//  Everything else lives in a single always_ff and a single always_comb.
// TESTING
//  1. Reset, then 3 allocs, then wb trans_id 0,1,2 -> next cycle commit_instr_o[0].valid=1 (trans_id 0)
//     and [1].valid=1 (trans_id 1); ack=2'b11 -> next cycle [0] shows trans_id 2.
//  2. Fill 8 entries without ack -> issue_ready_o=0. Alloc+ack same cycle -> no alloc;
//     next cycle ready=1 and count=7.
//  3. Fill queue, retire in bursts of 2 while allocating -> tail wraps 7->0;
//     issue_trans_id_o and commit order stay monotonic mod 8.
//  4. wb to slot 1 only (slot 0 not done) -> [0].valid=0 and [1].valid=1; ack=2'b10 raises the
//     assertion; slot 1 must not retire before slot 0.
//  5. 5 entries occupied, flush_i together with issue_valid_i and wb -> next cycle empty_o=1,
//     all valid=0, issue_trans_id_o=0.
//  6. wb with ex.valid=1, cause=2 to the head -> [0].valid=1 and .ex.cause=2;
//     with COMMIT_QUEUE_WB_BYPASS_EN, valid=1 in the same cycle as the wb.

Source files
------------

// File: rtl/commit_queue_pkg.sv
// rtl/commit_queue_pkg.sv - shared types, sizes and helpers for the commit queue
// Contents: core configuration record, exception/scoreboard entry types,
// queue slot type and the ack prefix-length helper.
package commit_queue_pkg;

  // Core configuration record; only the port counts matter to the queue.
  typedef struct packed {
    int unsigned NrCommitPorts;
    int unsigned NrWbPorts;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{NrCommitPorts: 2, NrWbPorts: 2};

  localparam int unsigned XLEN          = 32;
  // Queue depth the trans_id width is derived from; the top NR_ENTRIES must match.
  localparam int unsigned CQ_NR_ENTRIES = 8;
  localparam int unsigned TRANS_ID_BITS = $clog2(CQ_NR_ENTRIES);

  typedef logic [TRANS_ID_BITS-1:0] cq_ptr_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
  } exception_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    cq_ptr_t         trans_id;
    logic [3:0]      fu;
    logic [7:0]      op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
    logic            valid;
    exception_t      ex;
  } scoreboard_entry_t;

  typedef struct packed {
    logic              occupied;
    logic              done;
    scoreboard_entry_t sbe;
  } cq_slot_t;

  // Number of leading ones in ack[n-1:0]; a gap ends the count.
  function automatic int prefix_len(input logic [31:0] ack, input int n);
    int   len;
    logic run;
    len = 0;
    run = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i < n) begin
        if (run && ack[i]) len = len + 1;
        else run = 1'b0;
      end
    end
    return len;
  endfunction

endpackage

// File: rtl/commit_queue_ptr.sv
// rtl/commit_queue_ptr.sv - wrapping queue pointer with variable increment and sync clear
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high reset
//   clear in   synchronous clear (flush)
//   inc   in   increment amount this cycle
//   ptr   out  current pointer value, wraps modulo 2**PTR_W
module commit_queue_ptr #(
  parameter int unsigned PTR_W = 3,
  parameter int unsigned INC_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [INC_W-1:0] inc,
  output logic [PTR_W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst || clear) ptr <= '0;
    else              ptr <= ptr + PTR_W'(inc);
  end

endmodule

// File: rtl/commit_queue.sv
// rtl/commit_queue.sv - in-order commit buffer feeding the commit stage
// Option macro: COMMIT_QUEUE_WB_BYPASS_EN forwards same-cycle writebacks to commit_instr_o.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   flush_i              discard all entries
//   issue_valid_i/_instr_i/_ready_o/_trans_id_o  allocation in program order
//   wb_valid_i/_trans_id_i/_result_i/_ex_i       per-port writeback
//   commit_instr_o       oldest entries, [0] oldest
//   commit_ack_i         prefix-contiguous retire strobes
//   empty_o              no occupied entries
module commit_queue
  import commit_queue_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg    = cva6_cfg_empty,
  parameter int unsigned NR_ENTRIES = CQ_NR_ENTRIES
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic                                             flush_i,
  input  logic                                             issue_valid_i,
  input  scoreboard_entry_t                                issue_instr_i,
  output logic                                             issue_ready_o,
  output logic [TRANS_ID_BITS-1:0]                         issue_trans_id_o,
  input  logic [CVA6Cfg.NrWbPorts-1:0]                     wb_valid_i,
  input  logic [CVA6Cfg.NrWbPorts-1:0][TRANS_ID_BITS-1:0]  wb_trans_id_i,
  input  logic [CVA6Cfg.NrWbPorts-1:0][XLEN-1:0]           wb_result_i,
  input  exception_t [CVA6Cfg.NrWbPorts-1:0]               wb_ex_i,
  output scoreboard_entry_t [CVA6Cfg.NrCommitPorts-1:0]    commit_instr_o,
  input  logic [CVA6Cfg.NrCommitPorts-1:0]                 commit_ack_i,
  output logic                                             empty_o
);

  localparam int NCP   = int'(CVA6Cfg.NrCommitPorts);
  localparam int NWB   = int'(CVA6Cfg.NrWbPorts);
  localparam int NE    = int'(NR_ENTRIES);
  localparam int CNT_W = $clog2(NR_ENTRIES + 1);
  localparam int INC_W = $clog2(CVA6Cfg.NrCommitPorts + 1);

  cq_slot_t          slots [NE];
  logic [CNT_W-1:0]  count;
  cq_ptr_t           head;
  cq_ptr_t           tail;

  logic              alloc;
  logic [INC_W-1:0]  npop;
  cq_ptr_t           idx;
  scoreboard_entry_t entry;
  logic              ack_gap;
  logic              ack_invalid;
  logic              wb_conflict;
  logic              unused_bits;

  commit_queue_ptr #(.PTR_W(TRANS_ID_BITS), .INC_W(INC_W)) u_head (
    .clk   (clk_i),
    .rst   (rst_i),
    .clear (flush_i),
    .inc   (npop),
    .ptr   (head)
  );

  commit_queue_ptr #(.PTR_W(TRANS_ID_BITS), .INC_W(INC_W)) u_tail (
    .clk   (clk_i),
    .rst   (rst_i),
    .clear (flush_i),
    .inc   (INC_W'(alloc)),
    .ptr   (tail)
  );

  always_comb begin
    // Readiness comes from the registered count only, so a retire never
    // frees a slot for an allocation in the same cycle.
    issue_ready_o    = (count != CNT_W'(NR_ENTRIES));
    issue_trans_id_o = tail;
    empty_o          = (count == '0);
    alloc            = issue_valid_i && issue_ready_o;
    npop             = INC_W'(prefix_len(32'(commit_ack_i), NCP));
    idx              = '0;
    entry            = '0;
    commit_instr_o   = '0;
    ack_gap          = 1'b0;
    ack_invalid      = 1'b0;
    wb_conflict      = 1'b0;
    // Incoming valid/trans_id and the stored valid bit are never consumed:
    // validity is rebuilt from occupied/done and trans_id from the slot index.
    unused_bits      = ^{issue_instr_i.valid, issue_instr_i.trans_id};
    for (int j = 0; j < NE; j++) unused_bits = unused_bits ^ slots[j].sbe.valid;

    for (int i = 0; i < NCP; i++) begin
      idx         = head + cq_ptr_t'(i);
      entry       = slots[idx].sbe;
      entry.valid = (CNT_W'(i) < count) && slots[idx].occupied && slots[idx].done;
`ifdef COMMIT_QUEUE_WB_BYPASS_EN
      // Higher port index is applied last and so wins on a collision.
      for (int k = 0; k < NWB; k++) begin
        if (wb_valid_i[k] && (wb_trans_id_i[k] == idx) && slots[idx].occupied &&
            (CNT_W'(i) < count)) begin
          entry.valid  = 1'b1;
          entry.result = wb_result_i[k];
          entry.ex     = wb_ex_i[k];
        end
      end
`endif
      commit_instr_o[i] = entry;
    end

    for (int i = 0; i < NCP; i++) begin
      if (commit_ack_i[i] && !commit_instr_o[i].valid) ack_invalid = 1'b1;
      if (i > 0 && commit_ack_i[i] && !commit_ack_i[i-1]) ack_gap = 1'b1;
    end

    for (int k = 0; k < NWB; k++) begin
      for (int m = k + 1; m < NWB; m++) begin
        if (wb_valid_i[k] && wb_valid_i[m] && (wb_trans_id_i[k] == wb_trans_id_i[m]))
          wb_conflict = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      count <= '0;
      for (int j = 0; j < NE; j++) begin
        slots[j].occupied <= 1'b0;
        slots[j].done     <= 1'b0;
      end
    end else begin
      count <= count + CNT_W'(alloc) - CNT_W'(npop);
      // The tail slot is free whenever alloc fires, so it never collides
      // with a retiring slot.
      if (alloc) begin
        slots[tail].occupied     <= 1'b1;
        slots[tail].done         <= 1'b0;
        slots[tail].sbe          <= issue_instr_i;
        slots[tail].sbe.trans_id <= tail;
      end
      for (int k = 0; k < NWB; k++) begin
        if (wb_valid_i[k] && slots[wb_trans_id_i[k]].occupied) begin
          slots[wb_trans_id_i[k]].done       <= 1'b1;
          slots[wb_trans_id_i[k]].sbe.result <= wb_result_i[k];
          slots[wb_trans_id_i[k]].sbe.ex     <= wb_ex_i[k];
        end
      end
      // Retire last so that clearing beats a late writeback to the same slot.
      for (int i = 0; i < NCP; i++) begin
        if (i < int'(npop)) begin
          slots[head + cq_ptr_t'(i)].occupied <= 1'b0;
          slots[head + cq_ptr_t'(i)].done     <= 1'b0;
        end
      end
    end
  end

  a_ack_prefix : assert property (@(posedge clk_i) disable iff (rst_i) !ack_gap);
  a_ack_valid  : assert property (@(posedge clk_i) disable iff (rst_i) !ack_invalid);
  a_wb_unique  : assert property (@(posedge clk_i) disable iff (rst_i) !wb_conflict);

endmodule

// File: tb/tb_commit_queue.sv
// tb/tb_commit_queue.sv - self-checking bench for commit_queue against a queue model
module tb_commit_queue;
  import commit_queue_pkg::*;

  logic clk = 1'b0;
  logic rst, flush, issue_valid, issue_ready, empty;
  scoreboard_entry_t issue_instr;
  logic [TRANS_ID_BITS-1:0] issue_tid;
  logic [1:0] wb_valid;
  logic [1:0][TRANS_ID_BITS-1:0] wb_tid;
  logic [1:0][XLEN-1:0] wb_result;
  exception_t [1:0] wb_ex;
  scoreboard_entry_t [1:0] commit_instr;
  logic [1:0] commit_ack;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  commit_queue dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_instr_i(issue_instr),
    .issue_ready_o(issue_ready), .issue_trans_id_o(issue_tid),
    .wb_valid_i(wb_valid), .wb_trans_id_i(wb_tid), .wb_result_i(wb_result), .wb_ex_i(wb_ex),
    .commit_instr_o(commit_instr), .commit_ack_i(commit_ack), .empty_o(empty)
  );

  typedef struct {
    int          id;
    logic [31:0] pc;
    bit          done;
    logic [31:0] result;
    bit          exv;
    logic [31:0] cause;
  } m_ent_t;

  m_ent_t mq[$];
  int next_id = 0;
  bit model_ok = 0;
  logic [31:0] pc_seq = 32'h8000_0000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: program-order list of live instructions.
  always @(posedge clk) begin
    if (rst || flush) begin
      mq.delete();
      next_id = 0;
      if (rst) model_ok = 1;
    end else begin
      bit do_alloc;
      int n;
      do_alloc = issue_valid && (mq.size() < 8);
      for (int k = 0; k < 2; k++)
        if (wb_valid[k])
          foreach (mq[j])
            if (mq[j].id == int'(wb_tid[k])) begin
              mq[j].done = 1; mq[j].result = wb_result[k];
              mq[j].exv = wb_ex[k].valid; mq[j].cause = wb_ex[k].cause;
            end
      n = commit_ack[0] ? (commit_ack[1] ? 2 : 1) : 0;
      repeat (n) void'(mq.pop_front());
      if (do_alloc) begin
        mq.push_back('{id: next_id, pc: issue_instr.pc, done: 0, result: 0, exv: 0, cause: 0});
        next_id = (next_id + 1) % 8;
      end
    end
  end

  // Compare process: outputs against the model every cycle.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("issue_ready", 64'(issue_ready), 64'(mq.size() < 8));
      chk("issue_trans_id", 64'(issue_tid), 64'(next_id));
      chk("empty", 64'(empty), 64'(mq.size() == 0));
      for (int i = 0; i < 2; i++) begin
        if (i < mq.size()) begin
          m_ent_t e;
          e = mq[i];
`ifdef COMMIT_QUEUE_WB_BYPASS_EN
          for (int k = 0; k < 2; k++)
            if (wb_valid[k] && int'(wb_tid[k]) == e.id) begin
              e.done = 1; e.result = wb_result[k]; e.exv = wb_ex[k].valid; e.cause = wb_ex[k].cause;
            end
`endif
          chk($sformatf("valid[%0d]", i), 64'(commit_instr[i].valid), 64'(e.done));
          chk($sformatf("trans_id[%0d]", i), 64'(commit_instr[i].trans_id), 64'(e.id));
          chk($sformatf("pc[%0d]", i), 64'(commit_instr[i].pc), 64'(e.pc));
          if (e.done) begin
            chk($sformatf("result[%0d]", i), 64'(commit_instr[i].result), 64'(e.result));
            chk($sformatf("ex_valid[%0d]", i), 64'(commit_instr[i].ex.valid), 64'(e.exv));
            chk($sformatf("ex_cause[%0d]", i), 64'(commit_instr[i].ex.cause), 64'(e.cause));
          end
        end else begin
          chk($sformatf("valid[%0d]", i), 64'(commit_instr[i].valid), 64'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; wb_valid = '0; commit_ack = '0; flush = 0;
  endtask

  task automatic set_issue();
    issue_valid = 1;
    issue_instr = '0;
    issue_instr.pc = pc_seq;
    issue_instr.op = 8'($urandom);
    issue_instr.rd = 5'($urandom);
    issue_instr.valid = 1;
    pc_seq = pc_seq + 4;
  endtask

  task automatic set_wb(input int port, input int id, input bit exv, input int cause);
    wb_valid[port] = 1;
    wb_tid[port] = TRANS_ID_BITS'(id);
    wb_result[port] = $urandom;
    wb_ex[port] = '{valid: exv, cause: 32'(cause), tval: '0};
  endtask

  task automatic wb_pending();
    int n = 0;
    foreach (mq[j]) if (!mq[j].done && n < 2) begin set_wb(n, mq[j].id, 0, 0); n++; end
  endtask

  function automatic logic [1:0] model_ack();
    logic [1:0] a = 2'b00;
    if (mq.size() > 0 && mq[0].done) a[0] = 1;
    if (a[0] && mq.size() > 1 && mq[1].done) a[1] = 1;
    return a;
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1; issue_instr = '0; wb_tid = '0; wb_result = '0; wb_ex = '0;
    idle();
    tick(); tick();
    rst = 0;
    chk("rst_ready", 64'(issue_ready), 64'd1);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_valid0", 64'(commit_instr[0].valid), 64'd0);
    chk("rst_valid1", 64'(commit_instr[1].valid), 64'd0);

    // 1: three allocs, writebacks, dual retire
    repeat (3) begin set_issue(); tick(); end
    idle(); set_wb(0, 0, 0, 0); set_wb(1, 1, 0, 0); tick();
    idle();
    chk("t1_v0", 64'(commit_instr[0].valid), 64'd1);
    chk("t1_id0", 64'(commit_instr[0].trans_id), 64'd0);
    chk("t1_v1", 64'(commit_instr[1].valid), 64'd1);
    chk("t1_id1", 64'(commit_instr[1].trans_id), 64'd1);
    set_wb(0, 2, 0, 0); commit_ack = 2'b11; tick();
    idle();
    chk("t1_head_id", 64'(commit_instr[0].trans_id), 64'd2);
    chk("t1_head_v", 64'(commit_instr[0].valid), 64'd1);
    commit_ack = 2'b01; tick(); idle();
    chk("t1_empty", 64'(empty), 64'd1);

    // 2: full queue, alloc refused in the retire cycle
    repeat (8) begin set_issue(); tick(); end
    idle();
    chk("t2_full_ready", 64'(issue_ready), 64'd0);
    set_wb(0, mq[0].id, 0, 0); tick(); idle();
    set_issue(); commit_ack = 2'b01; tick(); idle();
    chk("t2_ready", 64'(issue_ready), 64'd1);
    chk("t2_count", 64'(mq.size()), 64'd7);

    // 3: steady retire while allocating, tail wraps
    repeat (20) begin
      set_issue(); wb_pending(); commit_ack = model_ack(); tick(); idle();
    end
    repeat (12) begin
      wb_pending(); commit_ack = model_ack(); tick(); idle();
    end
    chk("t3_empty", 64'(empty), 64'd1);

    // 4: younger entry done first must wait for the head
    flush = 1; tick(); idle();
    chk("t4_tid_restart", 64'(issue_tid), 64'd0);
    repeat (2) begin set_issue(); tick(); end
    idle(); set_wb(0, 1, 0, 0); tick(); idle();
    chk("t4_v0", 64'(commit_instr[0].valid), 64'd0);
    chk("t4_v1", 64'(commit_instr[1].valid), 64'd1);
    tick();
    chk("t4_hold_id0", 64'(commit_instr[0].trans_id), 64'd0);
    set_wb(0, 0, 0, 0); tick(); idle();
    commit_ack = 2'b11; tick(); idle();

    // 5: flush overrides alloc and writeback
    repeat (5) begin set_issue(); tick(); end
    idle(); set_wb(0, mq[0].id, 0, 0); set_wb(1, mq[1].id, 0, 0); tick(); idle();
    flush = 1; set_issue(); set_wb(0, mq[2].id, 0, 0); tick(); idle();
    chk("t5_empty", 64'(empty), 64'd1);
    chk("t5_v0", 64'(commit_instr[0].valid), 64'd0);
    chk("t5_v1", 64'(commit_instr[1].valid), 64'd1 - 64'd1);
    chk("t5_tid", 64'(issue_tid), 64'd0);

    // 6: exception writeback to the head
    set_issue(); tick(); idle();
    set_wb(0, 0, 1, 2);
    #1;
`ifdef COMMIT_QUEUE_WB_BYPASS_EN
    chk("t6_bypass_v", 64'(commit_instr[0].valid), 64'd1);
    chk("t6_bypass_cause", 64'(commit_instr[0].ex.cause), 64'd2);
`else
    chk("t6_same_cycle_v", 64'(commit_instr[0].valid), 64'd0);
`endif
    tick(); idle();
    chk("t6_v", 64'(commit_instr[0].valid), 64'd1);
    chk("t6_exv", 64'(commit_instr[0].ex.valid), 64'd1);
    chk("t6_cause", 64'(commit_instr[0].ex.cause), 64'd2);
    commit_ack = 2'b01; tick(); idle();
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
